// File: rtl/wom_stream1k16_pkg.sv
// Shared constants and FSM encoding for the write-only-port stream reader.
package wom_stream1k16_pkg;

    localparam int WOM_DEPTH_LOG2 = 10;
    localparam int WOM_WIDTH      = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } wom_state_t;

endpackage

// File: rtl/wom_skid_fifo2.sv
// Two-entry synchronous FIFO that absorbs RAM read latency under backpressure.
module wom_skid_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] slot [2];
    logic             wr_idx;
    logic             rd_idx;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_idx  <= 1'b0;
            rd_idx  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_idx] <= push_data;
                wr_idx       <= ~wr_idx;
            end
            if (do_pop) begin
                rd_idx <= ~rd_idx;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_data  = slot[rd_idx];
    assign head_valid = (count != 2'd0);
    assign occupancy  = count;

endmodule

// File: rtl/wom_stream1k16.sv
// 1K x 16 buffer filled by the CPU write port and streamed out over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; len=0 start only pulses done
// RUN   | issuing reads and draining the FIFO until xfer_cnt hits 0
module wom_stream1k16
    import wom_stream1k16_pkg::*;
#(
    parameter int DEPTH_LOG2 = WOM_DEPTH_LOG2,
    parameter int WIDTH      = WOM_WIDTH
) (
    input  logic                  CLK,
    input  logic                  HRESETn,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_en,
    input  logic                  start,
    input  logic [DEPTH_LOG2-1:0] base,
    input  logic [DEPTH_LOG2:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
    localparam logic [2:0]            CREDITS = 3'd2;

    wom_state_t state;
    wom_state_t state_next;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_inflight;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   issue_cnt;
    logic [DEPTH_LOG2:0]   xfer_cnt;
    logic [1:0]            fifo_occ;
    logic [2:0]            credit_used;
    logic                  xfer;
    logic                  issue;
    logic                  start_go;
    logic                  start_zero;
    logic                  last_xfer;

    assign xfer        = m_valid && m_ready;
    assign credit_used = {1'b0, fifo_occ} + {2'b00, rd_inflight};
    assign start_go    = (state == ST_IDLE) && start && (len != '0);
    assign start_zero  = (state == ST_IDLE) && start && (len == '0);
    assign last_xfer   = (state == ST_RUN) && xfer && (xfer_cnt == CNT_ONE);

    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_go)  state_next = ST_RUN;
            ST_RUN:  if (last_xfer) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A word popped this cycle frees its slot in time for a read issued now,
    // which is what keeps the stream bubble-free with m_ready held high.
    always_comb begin
        busy  = (state == ST_RUN);
        issue = (state == ST_RUN) && (issue_cnt != '0)
                && (credit_used < (CREDITS + {2'b00, xfer}));
    end

    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_ptr      <= '0;
            issue_cnt   <= '0;
            xfer_cnt    <= '0;
            rd_inflight <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_inflight <= issue;
            done        <= start_zero || last_xfer;
            if (start_go) begin
                rd_ptr    <= base;
                issue_cnt <= len;
                xfer_cnt  <= len;
            end else begin
                if (issue) begin
                    rd_ptr    <= rd_ptr + PTR_ONE;
                    issue_cnt <= issue_cnt - CNT_ONE;
                end
                if (xfer && (state == ST_RUN)) begin
                    xfer_cnt <= xfer_cnt - CNT_ONE;
                end
            end
        end
    end

    // Unreset RAM; a same-address write and read returns the old word.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            rd_data <= mem[rd_ptr];
        end
    end

    wom_skid_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (HRESETn),
        .push       (rd_inflight),
        .push_data  (rd_data),
        .pop        (m_ready),
        .head_data  (m_data),
        .head_valid (m_valid),
        .occupancy  (fifo_occ)
    );

endmodule

// File: tb/tb_wom_stream1k16.sv
// Bench for wom_stream1k16: vector table of stream commands plus corner-case sequences.
module tb_wom_stream1k16;

    logic        CLK = 1'b0;
    logic        HRESETn;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        start;
    logic [9:0]  base;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;

    always #5 CLK = ~CLK;

    wom_stream1k16 dut (
        .CLK     (CLK),
        .HRESETn (HRESETn),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .start   (start),
        .base    (base),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_lat;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          hs_cnt  = 0;
    logic [15:0] model [1024];
    logic [15:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard side: every handshake pops one expected word.
    always @(negedge CLK) begin
        if (!HRESETn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'b0, m_valid}, 32'd1);
                check("stall_data", {16'b0, m_data}, {16'b0, prev_data});
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_xfer: got word %0h, expected none", m_data);
                end else begin
                    check("stream_data", {16'b0, m_data}, {16'b0, exp_q.pop_front()});
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic wr(input int a, input logic [15:0] d);
        wr_addr = a[9:0];
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge CLK);
        #1;
        wr_en    = 1'b0;
        model[a] = d;
    endtask

    task automatic launch(input int b, input int l);
        for (int i = 0; i < l; i++) exp_q.push_back(model[(b + i) % 1024]);
        base  = b[9:0];
        len   = l[10:0];
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_stream(input string tag, input int l, input int mode, input int exp_lat,
                                 input int c0, input int h0, input int poke);
        int cycles   = c0;
        int first    = -1;
        int done_at  = -1;
        int done_cnt = 0;
        int limit    = 60 + 12 * l;
        bit busy_bad = 1'b0;
        bit valid_seen = 1'b0;
        forever begin
            if (m_valid) begin
                valid_seen = 1'b1;
                if (first < 0) first = cycles;
            end
            if (l > 0 && cycles == 1) check({tag, "_busy_high"}, {31'b0, busy}, 32'd1);
            if (l == 0 && busy) busy_bad = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cycles;
                    check({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
                end
            end
            if ((done_at >= 0 && cycles >= done_at + 3) || cycles >= limit) break;
            if (mode == 0) m_ready = 1'b1;
            else m_ready = ((cycles % 11) >= 3 && (cycles % 11) < 8) ? 1'b0 : 1'($urandom_range(0, 1));
            if (cycles == poke) begin
                start = 1'b1;
                base  = 10'd900;
                len   = 11'd3;
            end
            @(posedge CLK);
            #1;
            start = 1'b0;
            cycles++;
        end
        m_ready = 1'b1;
        if (done_at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected a done pulse", tag, cycles);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_handshakes"}, hs_cnt - h0, l);
        check({tag, "_left_in_q"}, exp_q.size(), 0);
        if (exp_lat >= 0 && l > 0) check({tag, "_first_lat"}, first, exp_lat);
        if (mode == 0 && l > 0) check({tag, "_done_time"}, done_at, l + 2);
        if (l == 0) begin
            check({tag, "_busy_never"}, {31'b0, busy_bad}, 32'd0);
            check({tag, "_valid_never"}, {31'b0, valid_seen}, 32'd0);
        end
        exp_q.delete();
    endtask

    task automatic do_stream(input string tag, input int b, input int l, input int mode, input int exp_lat);
        int h0 = hs_cnt;
        launch(b, l);
        finish_stream(tag, l, mode, exp_lat, 0, h0, -1);
    endtask

    initial begin
        int h0;
        int guard;
        vecs[0] = '{base: 0,    len: 16,   mode: 0, exp_lat: 2};
        vecs[1] = '{base: 1020, len: 8,    mode: 0, exp_lat: 2};
        vecs[2] = '{base: 3,    len: 8,    mode: 1, exp_lat: -1};
        vecs[3] = '{base: 1023, len: 1,    mode: 0, exp_lat: 2};
        vecs[4] = '{base: 10,   len: 1024, mode: 0, exp_lat: 2};
        vecs[5] = '{base: 600,  len: 12,   mode: 1, exp_lat: -1};

        HRESETn = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_valid", {31'b0, m_valid}, 32'd0);
        check("rst_data", {16'b0, m_data}, 32'd0);
        HRESETn = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 1024; i++) wr(i, 16'(32'h1234 + i * 7));
        for (int i = 0; i < 16; i++) wr(i, 16'(32'hA000 + i));
        wr(1022, 16'd1);
        wr(1023, 16'd2);

        for (int v = 0; v < 6; v++) begin
            do_stream($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_lat);
        end

        // Wrap across the top of the buffer.
        wr(0, 16'd3);
        wr(1, 16'd4);
        do_stream("wrap", 1022, 4, 0, 2);

        // Write to address 5 lands on the same edge its read is registered.
        h0 = hs_cnt;
        launch(5, 2);
        wr_addr = 10'd5;
        wr_data = 16'hBEEF;
        wr_en   = 1'b1;
        @(posedge CLK);
        #1;
        wr_en    = 1'b0;
        model[5] = 16'hBEEF;
        finish_stream("collide", 2, 0, 2, 1, h0, -1);
        do_stream("restream", 5, 1, 0, 2);

        do_stream("len0", 7, 0, 0, -1);

        h0 = hs_cnt;
        launch(100, 6);
        finish_stream("start_busy", 6, 0, 2, 0, h0, 2);

        // Reset after the third transfer of a 10-word stream.
        h0 = hs_cnt;
        launch(0, 10);
        guard = 0;
        while (hs_cnt - h0 < 3 && guard < 40) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        check("rst_mid_xfers", hs_cnt - h0, 3);
        HRESETn = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, m_valid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_data", {16'b0, m_data}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        HRESETn = 1'b1;
        @(posedge CLK);
        #1;
        do_stream("after_rst", 0, 2, 0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
